// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and sample/vector types for the 8x8 DCT
// transpose buffer.
//   DCT_W    : width of one signed sample (row-pass output width)
//   DCT_N    : block dimension (8x8 blocks)
//   DCT_AW   : width of a row/column index within a block
//   sample_t : one signed sample
//   vec_t    : one row or one column of DCT_N samples
package dct_pkg;

  localparam int DCT_W  = 16;
  localparam int DCT_N  = 8;
  localparam int DCT_AW = $clog2(DCT_N);

  typedef logic signed [DCT_W-1:0] sample_t;
  typedef sample_t [DCT_N-1:0]     vec_t;

endpackage

// File: rtl/dct_tp_bank.sv
// dct_tp_bank: one N x N sample store of the transpose buffer.
// A whole row is written in one cycle. A whole column is read
// combinationally through a per-row column mux. The data array has no
// reset; the owning controller tracks validity with its full flags.
//   clk     : clock, write on rising edge
//   wr_en   : write wr_data into row wr_row
//   wr_row  : row index to write
//   wr_data : row samples, index = column
//   rd_col  : column index to read
//   rd_data : column samples, index = row
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int W  = DCT_W,
  parameter int N  = DCT_N,
  parameter int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_row,
  input  logic signed [W-1:0] wr_data [N],
  input  logic [AW-1:0]       rd_col,
  output logic signed [W-1:0] rd_data [N]
);

  logic signed [W-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][c] <= wr_data[c];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      rd_data[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// dct_transpose: double-buffered 8x8 transpose between the row and
// column passes of a 2-D DCT. Rows go in; columns of the same block
// come out. Samples pass bit-exact. Only N = 8 is supported.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : row handshake
//   in_sob              : accepted row is row 0 of a new block
//   in_data[c]          : row sample for column c
//   out_valid/out_ready : column handshake
//   out_data[r]         : column sample for row r
//   out_sob/out_eob     : first / last column of a block
//   err_align           : sticky, a partial block was cut short by in_sob
module dct_transpose
  import dct_pkg::*;
#(
  parameter int W = DCT_W,
  parameter int N = DCT_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sob,
  input  logic signed [W-1:0] in_data [N],
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data [N],
  output logic                out_sob,
  output logic                out_eob,
  output logic                err_align
);

  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [1:0]          full;
  logic                wr_sel;
  logic                rd_sel;
  logic [AW-1:0]       wr_row;
  logic [AW-1:0]       rd_col;
  logic [AW-1:0]       wr_idx;
  logic                wr_fire;
  logic                rd_fire;
  logic                wr_last;
  logic                rd_last;
  logic signed [W-1:0] bank0_rd [N];
  logic signed [W-1:0] bank1_rd [N];

  // Both handshakes depend only on registered state, so neither side
  // combinationally waits on the other.
  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // A start-of-block row always lands in row 0, abandoning whatever
  // partial block was being collected in the same bank.
  assign wr_idx  = in_sob ? '0 : wr_row;
  assign wr_last = wr_fire && !in_sob && (wr_row == LAST);
  assign rd_last = rd_fire && (rd_col == LAST);

  assign out_sob = out_valid && (rd_col == '0);
  assign out_eob = out_valid && (rd_col == LAST);

  dct_tp_bank #(.W(W), .N(N), .AW(AW)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire && !wr_sel),
    .wr_row  (wr_idx),
    .wr_data (in_data),
    .rd_col  (rd_col),
    .rd_data (bank0_rd)
  );

  dct_tp_bank #(.W(W), .N(N), .AW(AW)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire && wr_sel),
    .wr_row  (wr_idx),
    .wr_data (in_data),
    .rd_col  (rd_col),
    .rd_data (bank1_rd)
  );

  always_comb begin
    for (int r = 0; r < N; r++) begin
      out_data[r] = rd_sel ? bank1_rd[r] : bank0_rd[r];
    end
  end

  // Write side: row counter, bank pointer and alignment error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row    <= '0;
      wr_sel    <= 1'b0;
      err_align <= 1'b0;
    end else if (wr_fire) begin
      if (in_sob) begin
        wr_row <= AW'(1);
        if (wr_row != '0) begin
          err_align <= 1'b1;
        end
      end else if (wr_row == LAST) begin
        wr_row <= '0;
        wr_sel <= !wr_sel;
      end else begin
        wr_row <= wr_row + AW'(1);
      end
    end
  end

  // Read side: column counter and bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col <= '0;
      rd_sel <= 1'b0;
    end else if (rd_fire) begin
      if (rd_col == LAST) begin
        rd_col <= '0;
        rd_sel <= !rd_sel;
      end else begin
        rd_col <= rd_col + AW'(1);
      end
    end
  end

  // Full flags. A write can only target a non-full bank and a read only
  // a full one, so the set and the clear never hit the same bank in one
  // cycle and both take effect when they coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_last) begin
        full[wr_sel] <= 1'b1;
      end
      if (rd_last) begin
        full[rd_sel] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// tb_dct_transpose: self-checking bench for dct_transpose.
// A transpose model built from the driven rows pushes expected columns
// into a scoreboard queue; every cycle the presented column is compared
// with the queue head and popped when it is taken.
module tb_dct_transpose;
  import dct_pkg::*;

  localparam int W = DCT_W;
  localparam int N = DCT_N;

  typedef struct {
    vec_t col;
    bit   sob;
    bit   eob;
  } exp_t;

  typedef struct {
    bit in_valid;
    bit in_sob;
    bit out_ready;
    int row;
    bit exp_in_ready;
    bit exp_out_valid;
    bit exp_sob;
    bit exp_eob;
  } cyc_rec_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                in_sob;
  logic signed [W-1:0] in_data [N];
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data [N];
  logic                out_sob;
  logic                out_eob;
  logic                err_align;

  int       errors = 0;
  int       checks = 0;
  exp_t     sb[$];
  vec_t     model_blk [N];
  int       model_row = 0;
  bit       model_err = 1'b0;
  bit       was_stalled = 1'b0;
  vec_t     drv_row;
  cyc_rec_t tbl [17];

  dct_transpose #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sob    (in_sob),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .err_align (err_align)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t make_row(input int base, input int r);
    vec_t v;
    for (int c = 0; c < N; c++) v[c] = sample_t'(base + r * 8 + c);
    return v;
  endfunction

  task automatic model_accept();
    exp_t e;
    if (in_sob) begin
      if (model_row != 0) model_err = 1'b1;
      model_row = 0;
    end
    model_blk[model_row] = drv_row;
    if (model_row == N - 1) begin
      for (int c = 0; c < N; c++) begin
        for (int r = 0; r < N; r++) e.col[r] = model_blk[r][c];
        e.sob = (c == 0);
        e.eob = (c == N - 1);
        sb.push_back(e);
      end
      model_row = 0;
    end else begin
      model_row++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      model_row   = 0;
      model_err   = 1'b0;
      was_stalled = 1'b0;
      return;
    end
    if (was_stalled) check("hold_valid", out_valid, 1);
    if (in_valid && in_ready) model_accept();
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_col: out_valid=1 but no column expected at %0t", $time);
      end else begin
        e = sb[0];
        for (int r = 0; r < N; r++) check("col_data", $signed(out_data[r]), $signed(e.col[r]));
        check("col_sob", out_sob, e.sob);
        check("col_eob", out_eob, e.eob);
        if (out_ready) void'(sb.pop_front());
      end
    end
    was_stalled = out_valid && !out_ready;
  endtask

  task automatic to_negedge();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    to_negedge();
    to_drive();
  endtask

  task automatic set_row(input vec_t v, input bit sob);
    in_valid = 1'b1;
    in_sob   = sob;
    drv_row  = v;
    for (int c = 0; c < N; c++) in_data[c] = v[c];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sob   = 1'b0;
  endtask

  task automatic send_row(input vec_t v, input bit sob, output bit stalled);
    int n = 0;
    bit acc;
    set_row(v, sob);
    stalled = 1'b0;
    forever begin
      to_negedge();
      acc = in_ready;
      to_drive();
      if (acc) break;
      stalled = 1'b1;
      n++;
      if (n >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL row_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic send_block(input int base, input bit sob, output int stalls);
    bit s;
    stalls = 0;
    for (int r = 0; r < N; r++) begin
      send_row(make_row(base, r), sob && (r == 0), s);
      if (s) stalls++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain_queue", sb.size(), 0);
    check("drain_valid", out_valid, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    to_negedge();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sob", out_sob, 0);
    check("rst_out_eob", out_eob, 0);
    check("rst_err_align", err_align, 0);
    to_drive();
    rst_n = 1'b1;
  endtask

  initial begin
    int   stalls;
    bit   s;
    vec_t v;

    // Single block, cycle by cycle: rows 0..7, then columns 0..7.
    for (int k = 0; k < 17; k++) begin
      tbl[k].in_valid      = (k < 8);
      tbl[k].in_sob        = (k == 0);
      tbl[k].out_ready     = 1'b1;
      tbl[k].row           = k;
      tbl[k].exp_in_ready  = 1'b1;
      tbl[k].exp_out_valid = (k >= 8) && (k <= 15);
      tbl[k].exp_sob       = (k == 8);
      tbl[k].exp_eob       = (k == 15);
    end

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sob    = 1'b0;
    out_ready = 1'b1;
    drv_row   = '0;
    for (int c = 0; c < N; c++) in_data[c] = '0;
    to_drive();
    do_reset();

    $display("[TB] single block");
    for (int k = 0; k < 17; k++) begin
      if (tbl[k].in_valid) set_row(make_row(0, tbl[k].row), tbl[k].in_sob);
      else idle();
      out_ready = tbl[k].out_ready;
      to_negedge();
      check("tbl_in_ready", in_ready, tbl[k].exp_in_ready);
      check("tbl_out_valid", out_valid, tbl[k].exp_out_valid);
      check("tbl_out_sob", out_sob, tbl[k].exp_sob);
      check("tbl_out_eob", out_eob, tbl[k].exp_eob);
      to_drive();
    end
    idle();
    drain();
    check("single_err_align", err_align, 0);

    $display("[TB] back-to-back blocks");
    stalls = 0;
    for (int b = 0; b < 4; b++) begin
      int st;
      send_block(1000 * b, (b % 2) == 0, st);
      stalls += st;
    end
    idle();
    check("b2b_in_ready_drops", stalls, 0);
    drain();
    check("b2b_err_align", err_align, model_err);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    stalls = 0;
    for (int b = 0; b < 2; b++) begin
      int st;
      send_block(5000 + 100 * b, 1'b1, st);
      stalls += st;
    end
    idle();
    check("bp_stalls_16_rows", stalls, 0);
    to_negedge();
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    to_drive();
    for (int k = 0; k < 11; k++) tick();
    out_ready = 1'b1;
    drain();

    $display("[TB] sign extremes");
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) v[c] = ((r + c) % 2 != 0) ? 16'sh7FFF : 16'sh8000;
      send_row(v, r == 0, s);
    end
    idle();
    drain();

    $display("[TB] misalignment");
    for (int r = 0; r < 3; r++) send_row(make_row(500, r), 1'b0, s);
    send_block(600, 1'b1, stalls);
    idle();
    to_negedge();
    check("mis_err_model", model_err, 1);
    check("mis_err_align", err_align, 1);
    to_drive();
    drain();
    check("mis_err_sticky", err_align, 1);

    $display("[TB] reset mid-block");
    for (int r = 0; r < 5; r++) send_row(make_row(700, r), r == 0, s);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      to_negedge();
      check("post_rst_out_valid", out_valid, 0);
      to_drive();
    end
    send_block(800, 1'b1, stalls);
    idle();
    drain();
    check("post_rst_err_align", err_align, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
